i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) that answers transactions issued by the master driver BFM on the shared i2c_if bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs written bytes and hands them to a byte-stream user port.
- Serves read bytes from the user port, stretching SCL while no read byte is available.

Parameters:
- SLAVE_ADDR, 7'h68, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (minimum 2).

Ports:
- pclk  input  1  system clock; oversamples the bus (fpclk >= 16x fSCL).
- areset  input  1  asynchronous, active-low reset.
- scl_i  input  1  SCL line level (bus, pulled up).
- sda_i  input  1  SDA line level (bus, pulled up).
- scl_oe  output  1  1 = pull SCL low (clock stretch).
- sda_oe  output  1  1 = pull SDA low (ACK or data 0).
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-pclk pulse; rx_data valid.
- tx_data  input  8  next byte to return on a master read.
- tx_valid  input  1  tx_data available; consumed when tx_ack=1.
- tx_ack  output  1  one-pclk pulse; tx_data captured.
- busy  output  1  addressed transaction in progress.
- rw  output  1  R/W bit of the current addressed transaction (1 = read).
- stop_det  output  1  one-pclk pulse on every STOP seen on the bus.

Behaviour:
- One clock (pclk); reset is asynchronous and active-low (areset).
- Reset values: all outputs 0, rx_data 8'h00, state IDLE. Reset mid-transfer releases SDA/SCL immediately (asynchronously).
- Input conditioning:
  - scl_i/sda_i pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - Events are decoded from the synced signals:
    - SCL rise/fall;
    - START = SDA fall while SCL high;
    - STOP = SDA rise while SCL high.
- Bit timing:
  - Receive bits are sampled on the detected SCL rise, MSB first.
  - sda_oe changes only in the pclk after a detected SCL fall (never while SCL high), except the release on STOP/START.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
  - ADDR_ACK
  - RX_BYTE
  - RX_ACK
  - TX_LOAD
  - TX_BYTE
  - TX_ACKCHK
  - IGNORE
- ADDR:
  - After the 8th rise, compare bits[7:1] with SLAVE_ADDR.
  - Match: latch rw=bit0, busy=1, go to ADDR_ACK.
  - Mismatch: go to IGNORE; SDA is never driven.
- ADDR_ACK:
  - On the next SCL fall, sda_oe=1.
  - On the following fall, sda_oe=0, then go to RX_BYTE (rw=0) or TX_LOAD (rw=1).
- RX_BYTE:
  - After the 8th rise, rx_data updates and rx_valid pulses exactly 1 pclk after the detected rise.
  - There is no backpressure.
  - Then the byte is ACKed (RX_ACK) with the same timing as ADDR_ACK, returning to RX_BYTE.
- TX_LOAD: entered on the SCL fall ending the ACK phase.
  - If tx_valid=1: capture tx_data, pulse tx_ack, drive MSB (sda_oe = ~bit) in the same pclk, go to TX_BYTE.
  - If tx_valid=0: scl_oe=1 (stretch) until tx_valid=1. Then load, drive MSB, and release scl_oe one pclk later.
- TX_BYTE: drive bits 6..0 on successive SCL falls. On the fall after bit 0, sda_oe=0 and go to TX_ACKCHK.
- TX_ACKCHK: sample SDA on the SCL rise.
  - 0 (ACK): go to TX_LOAD.
  - 1 (NACK): go to IGNORE, busy stays 1 until STOP/START.
- IGNORE: SDA/SCL released; wait for STOP or START.
- Any state, START/repeated START (including mid-byte):
  - sda_oe=0, scl_oe=0;
  - clear the bit counter;
  - go to ADDR;
  - busy=0 until the next match.
- Any state, STOP:
  - stop_det pulse;
  - release both lines;
  - busy=0, go to IDLE;
  - a partially received byte is discarded (no rx_valid).
- A START and STOP can never both be detected in the same cycle. If a STOP and an SCL edge coincide, STOP wins.
- General-call (addr 0) and 10-bit addressing are not supported; both are treated as mismatch.

Test Plan:
- Write to 0x68 with bytes 0xA5, 0x3C, then STOP:
  - ACK on address and both bytes;
  - rx_valid pulses twice with rx_data 0xA5 then 0x3C;
  - stop_det pulses once;
  - busy returns to 0.
- Write to 0x21: no ACK (SDA stays high in the 9th clock), no rx_valid, busy stays 0, stop_det pulses at STOP.
- Read from 0x68, tx_valid=1 with 0x96 then 0x0F; master ACKs then NACKs:
  - SDA bit pattern 10010110, then 00001111;
  - tx_ack pulses twice;
  - lines released after the NACK.
- Read with tx_valid held 0 for 200 pclk after the address ACK:
  - scl_oe=1 for the whole stall;
  - byte 0x5A is driven correctly once tx_valid rises;
  - scl_oe deasserts within 2 pclk.
- Write 0x68, send 4 bits of data, then repeated START + read 0x68:
  - no rx_valid for the partial byte;
  - new address ACKed, rw=1.
- Assert areset while sda_oe=1 during an ACK: sda_oe/scl_oe drop immediately; after release, the block recognizes a fresh START+address.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match,
// byte-stream write port and stretched read port.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       areset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       busy,
  output logic       rw,
  output logic       stop_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACKCHK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d, scl_s, sda_s;
  logic       scl_rise, scl_fall, start, stop;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, rx_byte, rx_data_n;
  logic       ack_ph, ack_ph_n;
  logic       sda_oe_n, scl_oe_n, rx_valid_n, tx_ack_n, busy_n, rw_n, stop_det_n;

  // Idle bus is high, so synchronizers reset to 1 to avoid phantom events.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte  = {shreg[6:0], sda_s};

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ack_ph   <= 1'b0;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      ack_ph   <= ack_ph_n;
      sda_oe   <= sda_oe_n;
      scl_oe   <= scl_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_ack   <= tx_ack_n;
      busy     <= busy_n;
      rw       <= rw_n;
      stop_det <= stop_det_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ack_ph_n   = ack_ph;
    sda_oe_n   = sda_oe;
    scl_oe_n   = scl_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_ack_n   = 1'b0;
    busy_n     = busy;
    rw_n       = rw;
    stop_det_n = 1'b0;
    if (stop) begin
      stop_det_n = 1'b1;
      sda_oe_n   = 1'b0;
      scl_oe_n   = 1'b0;
      busy_n     = 1'b0;
      bit_cnt_n  = '0;
      state_n    = IDLE;
    end else if (start) begin
      sda_oe_n  = 1'b0;
      scl_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
      state_n   = ADDR;
    end else begin
      case (state)
        ADDR, RX_BYTE: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ack_ph_n = 1'b0;
            if (state == RX_BYTE) begin
              rx_data_n  = rx_byte;
              rx_valid_n = 1'b1;
              state_n    = RX_ACK;
            end else if (rx_byte[7:1] == SLAVE_ADDR) begin
              rw_n    = rx_byte[0];
              busy_n  = 1'b1;
              state_n = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        // First fall opens the ACK slot, second fall closes it.
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!ack_ph) begin
            sda_oe_n = 1'b1;
            ack_ph_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = (state == ADDR_ACK && rw) ? TX_LOAD : RX_BYTE;
          end
        end
        TX_LOAD: if (tx_valid) begin
          shreg_n   = {tx_data[6:0], 1'b0};
          sda_oe_n  = ~tx_data[7];
          tx_ack_n  = 1'b1;
          bit_cnt_n = '0;
          state_n   = TX_BYTE;
        end else begin
          scl_oe_n = 1'b1;
        end
        // A stretch is released here, one pclk after the MSB went out.
        TX_BYTE: begin
          scl_oe_n = 1'b0;
          if (scl_fall) begin
            if (bit_cnt != 3'd7) begin
              sda_oe_n  = ~shreg[7];
              shreg_n   = {shreg[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 3'd1;
            end else begin
              sda_oe_n = 1'b0;
              ack_ph_n = 1'b0;
              state_n  = TX_ACKCHK;
            end
          end
        end
        TX_ACKCHK: begin
          if (scl_rise) begin
            if (sda_s) state_n = IGNORE;
            else       ack_ph_n = 1'b1;
          end else if (scl_fall && ack_ph) begin
            state_n = TX_LOAD;
          end
        end
        IGNORE: begin
          sda_oe_n = 1'b0;
          scl_oe_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: an open-drain master model drives the I2C target.
module tb_i2c_slave_responder;
  localparam int Q = 8;

  logic       pclk = 1'b0, areset = 1'b0;
  logic       m_scl_lo = 1'b0, m_sda_lo = 1'b0;
  logic       scl_line, sda_line;
  logic       scl_oe, sda_oe, rx_valid, tx_valid = 1'b0, tx_ack, busy, rw, stop_det;
  logic [7:0] rx_data, tx_data;
  logic [7:0] tx_tbl [8];
  logic [7:0] rx_log [16];
  int         rx_cnt = 0, tx_idx = 0, stop_cnt = 0;
  int         total = 0, passed = 0;

  assign scl_line = ~(m_scl_lo | scl_oe);
  assign sda_line = ~(m_sda_lo | sda_oe);
  assign tx_data  = tx_tbl[tx_idx % 8];

  i2c_slave_responder #(.SLAVE_ADDR(7'h68), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .areset(areset), .scl_i(scl_line), .sda_i(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .busy(busy),
    .rw(rw), .stop_det(stop_det)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 16] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_ack)   tx_idx   <= tx_idx + 1;
    if (stop_det) stop_cnt <= stop_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (!scl_line && t < 2000) begin @(negedge pclk); t++; end
    if (!scl_line) begin
      total++;
      $display("FAIL scl_release_timeout got scl=0 after %0d cycles exp scl=1", t);
    end
  endtask

  task automatic m_start();
    m_sda_lo = 1'b1; wait_cyc(2*Q);
    m_scl_lo = 1'b1; wait_cyc(Q);
  endtask

  task automatic m_rstart();
    m_sda_lo = 1'b0; wait_cyc(Q);
    m_scl_lo = 1'b0; wait_scl_high(); wait_cyc(Q);
    m_sda_lo = 1'b1; wait_cyc(Q);
    m_scl_lo = 1'b1; wait_cyc(Q);
  endtask

  task automatic m_stop();
    m_sda_lo = 1'b1; wait_cyc(Q);
    m_scl_lo = 1'b0; wait_scl_high(); wait_cyc(Q);
    m_sda_lo = 1'b0; wait_cyc(2*Q);
  endtask

  // One SCL clock: drive b while low, sample the line late in the high phase.
  task automatic m_bit(input logic b, output logic s);
    m_sda_lo = ~b; wait_cyc(Q);
    m_scl_lo = 1'b0; wait_scl_high(); wait_cyc(Q);
    s = sda_line; wait_cyc(Q);
    m_scl_lo = 1'b1; wait_cyc(Q);
  endtask

  task automatic m_write(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin m_bit(1'b1, s); d[i] = s; end
    m_bit(nack, s);
  endtask

  task automatic test_reset();
    wait_cyc(5);
    total++; if ({scl_oe, sda_oe, rx_valid, tx_ack, busy, rw, stop_det} !== 7'b0)
      $display("FAIL rst_outs got %b exp 0000000", {scl_oe, sda_oe, rx_valid, tx_ack, busy, rw, stop_det}); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data got %h exp 00", rx_data); else passed++;
    areset = 1'b1; wait_cyc(10);
    total++; if ({scl_oe, sda_oe, busy, stop_det} !== 4'b0)
      $display("FAIL post_rst_outs got %b exp 0000", {scl_oe, sda_oe, busy, stop_det}); else passed++;
  endtask

  task automatic test_write();
    logic a; int rx0 = rx_cnt, st0 = stop_cnt;
    m_start(); m_write(8'hD0, a);
    total++; if (a !== 1'b0) $display("FAIL wr_addr_ack got %b exp 0", a); else passed++;
    total++; if ({busy, rw} !== 2'b10) $display("FAIL wr_busy_rw got %b exp 10", {busy, rw}); else passed++;
    m_write(8'hA5, a);
    total++; if (a !== 1'b0) $display("FAIL wr_b0_ack got %b exp 0", a); else passed++;
    m_write(8'h3C, a);
    total++; if (a !== 1'b0) $display("FAIL wr_b1_ack got %b exp 0", a); else passed++;
    m_stop();
    total++; if (rx_cnt - rx0 !== 2) $display("FAIL wr_rx_count got %0d exp 2", rx_cnt - rx0); else passed++;
    total++; if (rx_log[rx0 % 16] !== 8'hA5) $display("FAIL wr_rx0 got %h exp a5", rx_log[rx0 % 16]); else passed++;
    total++; if (rx_log[(rx0 + 1) % 16] !== 8'h3C) $display("FAIL wr_rx1 got %h exp 3c", rx_log[(rx0 + 1) % 16]); else passed++;
    total++; if (stop_cnt - st0 !== 1) $display("FAIL wr_stop_count got %0d exp 1", stop_cnt - st0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL wr_busy_end got %b exp 0", busy); else passed++;
  endtask

  task automatic test_addr_mismatch();
    logic a; int rx0 = rx_cnt, st0 = stop_cnt;
    m_start(); m_write(8'h42, a);
    total++; if (a !== 1'b1) $display("FAIL nm_addr_ack got %b exp 1", a); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL nm_busy got %b exp 0", busy); else passed++;
    m_write(8'h55, a);
    total++; if (a !== 1'b1) $display("FAIL nm_data_ack got %b exp 1", a); else passed++;
    m_stop();
    total++; if (rx_cnt - rx0 !== 0) $display("FAIL nm_rx_count got %0d exp 0", rx_cnt - rx0); else passed++;
    total++; if (stop_cnt - st0 !== 1) $display("FAIL nm_stop_count got %0d exp 1", stop_cnt - st0); else passed++;
  endtask

  task automatic test_read();
    logic a; logic [7:0] d0, d1; int t0 = tx_idx;
    tx_tbl[t0 % 8] = 8'h96; tx_tbl[(t0 + 1) % 8] = 8'h0F; tx_valid = 1'b1;
    m_start(); m_write(8'hD1, a);
    total++; if ({a, rw} !== 2'b01) $display("FAIL rd_addr_ack_rw got %b exp 01", {a, rw}); else passed++;
    m_read(d0, 1'b0);
    m_read(d1, 1'b1);
    tx_valid = 1'b0;
    total++; if (d0 !== 8'h96) $display("FAIL rd_byte0 got %h exp 96", d0); else passed++;
    total++; if (d1 !== 8'h0F) $display("FAIL rd_byte1 got %h exp 0f", d1); else passed++;
    total++; if (tx_idx - t0 !== 2) $display("FAIL rd_tx_ack_count got %0d exp 2", tx_idx - t0); else passed++;
    total++; if ({sda_oe, scl_oe, busy} !== 3'b001)
      $display("FAIL rd_after_nack got %b exp 001", {sda_oe, scl_oe, busy}); else passed++;
    m_stop();
    total++; if (busy !== 1'b0) $display("FAIL rd_busy_end got %b exp 0", busy); else passed++;
  endtask

  task automatic test_stretch();
    logic a; logic [7:0] d; int t0 = tx_idx, bad = 0, n = 0;
    m_start(); m_write(8'hD1, a);
    total++; if (a !== 1'b0) $display("FAIL st_addr_ack got %b exp 0", a); else passed++;
    for (int i = 0; i < 200; i++) begin if (scl_oe !== 1'b1) bad++; @(negedge pclk); end
    total++; if (bad !== 0) $display("FAIL st_hold got %0d unstretched cycles exp 0", bad); else passed++;
    total++; if (tx_idx !== t0) $display("FAIL st_no_ack got %0d exp %0d", tx_idx, t0); else passed++;
    tx_tbl[t0 % 8] = 8'h5A; tx_valid = 1'b1;
    while (scl_oe && n < 10) begin @(posedge pclk); #1; n++; end
    @(negedge pclk); tx_valid = 1'b0;
    total++; if (n > 2) $display("FAIL st_release got %0d pclk exp <=2", n); else passed++;
    total++; if (tx_idx - t0 !== 1) $display("FAIL st_tx_ack got %0d exp 1", tx_idx - t0); else passed++;
    m_read(d, 1'b1);
    total++; if (d !== 8'h5A) $display("FAIL st_byte got %h exp 5a", d); else passed++;
    m_stop();
  endtask

  task automatic test_repeated_start();
    logic a, s; logic [7:0] d; int rx0 = rx_cnt;
    m_start(); m_write(8'hD0, a);
    total++; if (a !== 1'b0) $display("FAIL rs_wr_ack got %b exp 0", a); else passed++;
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b0, s);
    tx_tbl[tx_idx % 8] = 8'hC3; tx_valid = 1'b1;
    m_rstart(); m_write(8'hD1, a);
    total++; if (a !== 1'b0) $display("FAIL rs_rd_ack got %b exp 0", a); else passed++;
    total++; if ({busy, rw} !== 2'b11) $display("FAIL rs_busy_rw got %b exp 11", {busy, rw}); else passed++;
    m_read(d, 1'b1);
    tx_valid = 1'b0;
    total++; if (d !== 8'hC3) $display("FAIL rs_byte got %h exp c3", d); else passed++;
    m_stop();
    total++; if (rx_cnt - rx0 !== 0) $display("FAIL rs_partial_rx got %0d exp 0", rx_cnt - rx0); else passed++;
  endtask

  task automatic test_async_reset();
    logic a, s; int rx0;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(i == 7 || i == 6 || i == 4, s);
    m_sda_lo = 1'b0; wait_cyc(Q);
    total++; if (sda_oe !== 1'b1) $display("FAIL ar_ack_drive got %b exp 1", sda_oe); else passed++;
    #2 areset = 1'b0; #1;
    total++; if ({sda_oe, scl_oe} !== 2'b00) $display("FAIL ar_release got %b exp 00", {sda_oe, scl_oe}); else passed++;
    wait_cyc(4); areset = 1'b1; wait_cyc(4);
    m_stop();
    rx0 = rx_cnt;
    m_start(); m_write(8'hD0, a);
    total++; if (a !== 1'b0) $display("FAIL ar_fresh_ack got %b exp 0", a); else passed++;
    m_write(8'h11, a); m_stop();
    total++; if (rx_cnt - rx0 !== 1) $display("FAIL ar_rx_count got %0d exp 1", rx_cnt - rx0); else passed++;
    total++; if (rx_log[rx0 % 16] !== 8'h11) $display("FAIL ar_rx_data got %h exp 11", rx_log[rx0 % 16]); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tx_tbl[i] = 8'h00;
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_stretch();
    test_repeated_start();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
